// File: rtl/mem_axi_dpram_pipe_if.sv
// Write/read/clear bundle for the pipelined simple dual-port RAM.
// The master side drives addresses and data; the slave side is the RAM.
interface mem_axi_dpram_pipe_if #(
    parameter int WIDTH_AD = 10,
    parameter int WIDTH_DA = 32,
    parameter int WIDTH_DS = WIDTH_DA / 8
);
    logic [WIDTH_AD-1:0] WADDR;
    logic [WIDTH_DA-1:0] WDATA;
    logic [WIDTH_DS-1:0] WSTRB;
    logic                WEN;
    logic [WIDTH_AD-1:0] RADDR;
    logic                REN;
    logic [WIDTH_DA-1:0] RDATA;
    logic                RVALID;
    logic                CLR;
    logic                INIT_BUSY;

    modport master (
        output WADDR, WDATA, WSTRB, WEN,
        output RADDR, REN, CLR,
        input  RDATA, RVALID, INIT_BUSY
    );

    modport slave (
        input  WADDR, WDATA, WSTRB, WEN,
        input  RADDR, REN, CLR,
        output RDATA, RVALID, INIT_BUSY
    );
endinterface

// File: rtl/mem_axi_dpram_pipe.sv
// Simple dual-port byte-addressed RAM with 1/2-cycle read pipeline,
// selectable same-line collision policy and a zero-fill engine.
module mem_axi_dpram_pipe #(
    parameter int WIDTH_AD   = 10,
    parameter int WIDTH_DA   = 32,
    parameter int WIDTH_DS   = WIDTH_DA / 8,
    parameter int WIDTH_DSB  = $clog2(WIDTH_DS),
    parameter int RD_LATENCY = 1,
    parameter int RDW_MODE   = 1,
    parameter int INIT_ZERO  = 1
) (
    input logic RESETn,
    input logic CLK,
    mem_axi_dpram_pipe_if.slave bus
);
    localparam int LW    = WIDTH_AD - WIDTH_DSB;
    localparam int DEPTH = 1 << LW;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_FILL = 1'b1;

    logic [0:0]          state;
    logic [LW-1:0]       cnt;
    logic [WIDTH_DA-1:0] mem [DEPTH];

    logic [LW-1:0]       wline;
    logic [LW-1:0]       rline;
    logic                idle;
    logic                wr;
    logic                rd;
    logic [WIDTH_DA-1:0] rd_old;
    logic [WIDTH_DA-1:0] rd_mux;

    logic                s1_valid;
    logic [WIDTH_DA-1:0] s1_data;

    assign wline = bus.WADDR[WIDTH_AD-1:WIDTH_DSB];
    assign rline = bus.RADDR[WIDTH_AD-1:WIDTH_DSB];
    assign idle  = (state == S_IDLE);
    assign wr    = idle & bus.WEN;
    assign rd    = idle & bus.REN;

    assign bus.INIT_BUSY = (state == S_FILL);

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state <= (INIT_ZERO != 0) ? S_FILL : S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.CLR) state <= S_FILL;
                end
                S_FILL: begin
                    if (&cnt) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Array is left unreset so it can map onto block RAM.
    always @(posedge CLK) begin
        if (state == S_FILL) begin
            mem[cnt] <= '0;
        end else if (wr) begin
            for (int i = 0; i < WIDTH_DS; i++) begin
                if (bus.WSTRB[i]) mem[wline][8*i +: 8] <= bus.WDATA[8*i +: 8];
            end
        end
    end

    assign rd_old = mem[rline];

    always_comb begin
        rd_mux = rd_old;
        if (RDW_MODE != 0 && wr && wline == rline) begin
            for (int i = 0; i < WIDTH_DS; i++) begin
                if (bus.WSTRB[i]) rd_mux[8*i +: 8] = bus.WDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd;
            if (rd) s1_data <= rd_mux;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic                o_valid;
            logic [WIDTH_DA-1:0] o_data;

            always_ff @(posedge CLK or negedge RESETn) begin
                if (!RESETn) begin
                    o_valid <= 1'b0;
                    o_data  <= '0;
                end else begin
                    o_valid <= s1_valid;
                    if (s1_valid) o_data <= s1_data;
                end
            end

            assign bus.RDATA  = o_data;
            assign bus.RVALID = o_valid;
        end else begin : g_lat1
            assign bus.RDATA  = s1_data;
            assign bus.RVALID = s1_valid;
        end
    endgenerate

    generate
        if (WIDTH_DSB > 0) begin : g_lo
            logic unused_lo;
            assign unused_lo = ^{bus.WADDR[WIDTH_DSB-1:0],
                                 bus.RADDR[WIDTH_DSB-1:0]};
        end
    endgenerate

    // Zero-time backdoor access for simulation models.
    task automatic write(input logic [WIDTH_AD-1:0] addr,
                         input logic [WIDTH_DA-1:0] data,
                         input logic [WIDTH_DS-1:0] be);
        for (int i = 0; i < WIDTH_DS; i++) begin
            if (be[i]) mem[addr[WIDTH_AD-1:WIDTH_DSB]][8*i +: 8] <= data[8*i +: 8];
        end
    endtask

    task automatic read(input  logic [WIDTH_AD-1:0] addr,
                        output logic [WIDTH_DA-1:0] data);
        data = mem[addr[WIDTH_AD-1:WIDTH_DSB]];
    endtask
endmodule

// File: tb/tb_mem_axi_dpram_pipe.sv
// Directed bench: dut_a = latency 1 / WRITE_FIRST,
// dut_b = latency 2 / READ_FIRST, both driven with identical stimulus.
module tb_mem_axi_dpram_pipe;
    localparam int AD = 10;
    localparam int DA = 32;

    logic CLK    = 1'b0;
    logic RESETn = 1'b0;

    always #5 CLK = ~CLK;

    mem_axi_dpram_pipe_if #(.WIDTH_AD(AD), .WIDTH_DA(DA)) ia ();
    mem_axi_dpram_pipe_if #(.WIDTH_AD(AD), .WIDTH_DA(DA)) ib ();

    mem_axi_dpram_pipe #(
        .WIDTH_AD(AD), .WIDTH_DA(DA),
        .RD_LATENCY(1), .RDW_MODE(1), .INIT_ZERO(1)
    ) dut_a (
        .RESETn(RESETn), .CLK(CLK), .bus(ia.slave)
    );

    mem_axi_dpram_pipe #(
        .WIDTH_AD(AD), .WIDTH_DA(DA),
        .RD_LATENCY(2), .RDW_MODE(0), .INIT_ZERO(1)
    ) dut_b (
        .RESETn(RESETn), .CLK(CLK), .bus(ib.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic wen, input logic [AD-1:0] waddr,
                         input logic [DA-1:0] wdata, input logic [3:0] wstrb,
                         input logic ren, input logic [AD-1:0] raddr,
                         input logic clr);
        ia.WEN = wen; ia.WADDR = waddr; ia.WDATA = wdata; ia.WSTRB = wstrb;
        ia.REN = ren; ia.RADDR = raddr; ia.CLR = clr;
        ib.WEN = wen; ib.WADDR = waddr; ib.WDATA = wdata; ib.WSTRB = wstrb;
        ib.REN = ren; ib.RADDR = raddr; ib.CLR = clr;
    endtask

    task automatic idle_in();
        drive(1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b0);
    endtask

    task automatic scan(input logic [DA-1:0] exp, output int bad);
        logic [DA-1:0] d;
        bad = 0;
        for (int l = 0; l < 256; l++) begin
            dut_a.read(AD'(l * 4), d);
            if (d !== exp) bad++;
            dut_b.read(AD'(l * 4), d);
            if (d !== exp) bad++;
        end
    endtask

    // Counts cycles with INIT_BUSY high on each DUT, bounded at 400.
    task automatic count_fill(output int na, output int nb, output int rv);
        na = 0; nb = 0; rv = 0;
        for (int c = 0; c < 400; c++) begin
            if (!ia.INIT_BUSY && !ib.INIT_BUSY) break;
            na += int'(ia.INIT_BUSY);
            nb += int'(ib.INIT_BUSY);
            rv += int'(ia.RVALID) + int'(ib.RVALID);
            step();
        end
    endtask

    initial begin
        int na, nb, rv, bad;
        logic [DA-1:0] d;

        idle_in();
        RESETn = 1'b0;
        step();
        step();
        chk("rst_busy_a", 32'(ia.INIT_BUSY), 32'd1);
        chk("rst_busy_b", 32'(ib.INIT_BUSY), 32'd1);
        chk("rst_rdata_a", ia.RDATA, 32'h0);
        chk("rst_rdata_b", ib.RDATA, 32'h0);
        chk("rst_rvalid_a", 32'(ia.RVALID), 32'd0);
        chk("rst_rvalid_b", 32'(ib.RVALID), 32'd0);

        RESETn = 1'b1;
        count_fill(na, nb, rv);
        chk("init_len_a", 32'(na), 32'd256);
        chk("init_len_b", 32'(nb), 32'd256);
        scan(32'h0, bad);
        chk("init_zero", 32'(bad), 32'd0);

        drive(1'b1, 10'h010, 32'hAABBCCDD, 4'b0101, 1'b0, '0, 1'b0);
        step();
        drive(1'b0, '0, '0, 4'h0, 1'b1, 10'h013, 1'b0);
        step();
        chk("strb_v1_a", 32'(ia.RVALID), 32'd1);
        chk("strb_d_a", ia.RDATA, 32'h00BB00DD);
        chk("strb_v1_b", 32'(ib.RVALID), 32'd0);
        idle_in();
        step();
        chk("strb_v2_a", 32'(ia.RVALID), 32'd0);
        chk("strb_hold_a", ia.RDATA, 32'h00BB00DD);
        chk("strb_v2_b", 32'(ib.RVALID), 32'd1);
        chk("strb_d_b", ib.RDATA, 32'h00BB00DD);
        step();
        chk("strb_v3_b", 32'(ib.RVALID), 32'd0);

        drive(1'b1, 10'h010, 32'hFFFFFFFF, 4'h0, 1'b0, '0, 1'b0);
        step();
        idle_in();
        dut_a.read(10'h010, d);
        chk("strb0_a", d, 32'h00BB00DD);
        dut_b.read(10'h010, d);
        chk("strb0_b", d, 32'h00BB00DD);

        drive(1'b1, 10'h020, 32'h11223344, 4'hF, 1'b0, '0, 1'b0);
        step();
        drive(1'b1, 10'h020, 32'hFFEEDDCC, 4'b0011, 1'b1, 10'h020, 1'b0);
        step();
        chk("rdw_v_a", 32'(ia.RVALID), 32'd1);
        chk("rdw_wf_a", ia.RDATA, 32'h1122DDCC);
        idle_in();
        step();
        chk("rdw_v_b", 32'(ib.RVALID), 32'd1);
        chk("rdw_rf_b", ib.RDATA, 32'h11223344);
        drive(1'b0, '0, '0, 4'h0, 1'b1, 10'h020, 1'b0);
        step();
        chk("rdw_after_a", ia.RDATA, 32'h1122DDCC);
        idle_in();
        step();
        chk("rdw_after_b", ib.RDATA, 32'h1122DDCC);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, AD'(i * 4), DA'(i), 4'hF, 1'b0, '0, 1'b0);
            step();
        end
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, '0, '0, 4'h0, c < 8, AD'((c % 8) * 4), 1'b0);
            step();
            chk($sformatf("b2b_v_a%0d", c), 32'(ia.RVALID), 32'(c < 8));
            if (c < 8) chk($sformatf("b2b_d_a%0d", c), ia.RDATA, 32'(c));
            chk($sformatf("b2b_v_b%0d", c), 32'(ib.RVALID),
                32'(c >= 1 && c < 9));
            if (c >= 1 && c < 9)
                chk($sformatf("b2b_d_b%0d", c), ib.RDATA, 32'(c - 1));
        end
        idle_in();

        for (int i = 0; i < 256; i++) begin
            drive(1'b1, AD'(i * 4), 32'hFFFFFFFF, 4'hF, 1'b0, '0, 1'b0);
            step();
        end
        idle_in();
        dut_a.read(10'h3FC, d);
        chk("ones_a", d, 32'hFFFFFFFF);
        drive(1'b0, '0, '0, 4'h0, 1'b0, '0, 1'b1);
        step();
        chk("clr_busy_a", 32'(ia.INIT_BUSY), 32'd1);
        chk("clr_busy_b", 32'(ib.INIT_BUSY), 32'd1);
        drive(1'b1, 10'h000, 32'h12345678, 4'hF, 1'b1, 10'h000, 1'b0);
        count_fill(na, nb, rv);
        idle_in();
        chk("clr_len_a", 32'(na), 32'd256);
        chk("clr_len_b", 32'(nb), 32'd256);
        chk("clr_no_rvalid", 32'(rv), 32'd0);
        scan(32'h0, bad);
        chk("clr_zero", 32'(bad), 32'd0);
        step();
        chk("clr_idle_rv_a", 32'(ia.RVALID), 32'd0);

        RESETn = 1'b0;
        #2;
        chk("rst2_rdata_a", ia.RDATA, 32'h0);
        chk("rst2_rdata_b", ib.RDATA, 32'h0);
        step();
        RESETn = 1'b1;
        for (int c = 0; c < 100; c++) step();
        chk("mid_busy_a", 32'(ia.INIT_BUSY), 32'd1);
        RESETn = 1'b0;
        #2;
        chk("rst3_busy_a", 32'(ia.INIT_BUSY), 32'd1);
        chk("rst3_rvalid_a", 32'(ia.RVALID), 32'd0);
        chk("rst3_rvalid_b", 32'(ib.RVALID), 32'd0);
        chk("rst3_rdata_b", ib.RDATA, 32'h0);
        step();
        step();
        RESETn = 1'b1;
        count_fill(na, nb, rv);
        chk("refill_len_a", 32'(na), 32'd256);
        chk("refill_len_b", 32'(nb), 32'd256);

        drive(1'b0, '0, '0, 4'h0, 1'b1, 10'h004, 1'b0);
        step();
        idle_in();
        chk("post_v_a", 32'(ia.RVALID), 32'd1);
        chk("post_d_a", ia.RDATA, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_axi_dpram_pipe.md
Name: mem_axi_dpram_pipe

Overview:
Parametrised simple dual-port synchronous RAM with one write port and one read port, used as the backing store behind the AXI memory models in the DMA bench and subsystem.
- Adds a selectable read latency of 1 or 2 cycles with a read-valid strobe.
- Adds a selectable read-during-write collision policy.
- Adds a hardware zero-fill engine that runs after reset or on request.
- Byte-addressed; one line is WIDTH_DA bits wide.

Parameters:
WIDTH_AD, 10, byte-address width; memory size is 1<<WIDTH_AD bytes
WIDTH_DA, 32, line width in bits; multiple of 8, range 8..1024
WIDTH_DS, WIDTH_DA/8, byte lanes per line
WIDTH_DSB, clogb2(WIDTH_DS), byte-offset bits ignored in addresses
RD_LATENCY, 1, read latency in cycles; legal values 1 or 2
RDW_MODE, 1, same-line collision policy: 0=READ_FIRST (old data), 1=WRITE_FIRST (new bytes merged)
INIT_ZERO, 1, 1=zero-fill all lines after reset release; 0=no automatic fill

Ports:
RESETn  in  1  asynchronous active-low reset
CLK  in  1  clock, rising edge
WADDR  in  WIDTH_AD  write byte address; low WIDTH_DSB bits ignored
WDATA  in  WIDTH_DA  write data
WSTRB  in  WIDTH_DS  write byte enables
WEN  in  1  write enable
RADDR  in  WIDTH_AD  read byte address; low WIDTH_DSB bits ignored
REN  in  1  read enable
RDATA  out  WIDTH_DA  read data
RVALID  out  1  one-cycle pulse marking RDATA valid
CLR  in  1  one-cycle pulse requesting a zero-fill
INIT_BUSY  out  1  high while zero-fill is in progress

Behaviour:
- Reset is RESETn, asynchronous, active-low; clock is CLK.
- Reset values:
  - RDATA=0, RVALID=0, all pipeline stages cleared.
  - INIT_BUSY=INIT_ZERO; fill counter=0.
  - Memory array contents are not reset.
- Depth is DEPTH=1<<(WIDTH_AD-WIDTH_DSB) lines. Line index is ADDR[WIDTH_AD-1:WIDTH_DSB].
- FSM states:
  - IDLE.
  - FILL: write all-zero line[cnt]; cnt increments each cycle.
  - After cnt==DEPTH-1 is written, go to IDLE, clear cnt, drop INIT_BUSY.
  - Fill takes exactly DEPTH cycles.
- FSM transitions:
  - First state after reset release: FILL if INIT_ZERO=1, else IDLE.
  - CLR=1 in IDLE: enter FILL next cycle.
  - CLR while in FILL is ignored.
  - Reset asserted mid-fill aborts the fill; it restarts from line 0 after release if INIT_ZERO=1.
- During FILL, WEN and REN are ignored: no writes, no RVALID. Pipeline contents already in flight still drain.
- Write (IDLE, WEN=1):
  - For each lane i with WSTRB[i]=1, mem[wline] byte i <= WDATA byte i at the rising edge.
  - WSTRB=0 leaves the line unchanged.
- Read (IDLE, REN=1 at edge T):
  - Stage 1 captures mem[rline].
  - RD_LATENCY=1: RDATA updates and RVALID=1 during the cycle after edge T.
  - RD_LATENCY=2: an extra output register delays RDATA/RVALID by one more cycle.
  - Back-to-back reads give one result per cycle, in order.
  - RDATA holds its last value when RVALID=0.
- Collision (IDLE, WEN=1, REN=1, wline==rline):
  - READ_FIRST: returns the full pre-write line.
  - WRITE_FIRST: lane i returns WDATA byte i if WSTRB[i]=1, else the old byte.
  - Memory is updated in both modes.
  - Different lines: independent; no interaction.
- Address wrap: none needed; indices are bit-sliced, so any WIDTH_AD value maps in range.
- Simulation-only backdoor tasks write(addr,data,be) and read(addr,data) access the array directly with zero time and bypass the FSM.

Test Plan:
- Reset, INIT_ZERO=1, WIDTH_AD=10, WIDTH_DA=32 (DEPTH=256) -> INIT_BUSY high for exactly 256 cycles after release; backdoor read of lines 0..255 all return 0.
- WEN, WADDR=0x010, WDATA=0xAABBCCDD, WSTRB=4'b0101; then REN RADDR=0x013 -> RDATA=0x00BB00DD one cycle after the read edge (RD_LATENCY=1), or two cycles after (RD_LATENCY=2), RVALID single pulse.
- Line 0x20 preloaded 0x11223344; same-cycle WEN/REN to 0x20 with WDATA=0xFFEEDDCC, WSTRB=4'b0011 -> READ_FIRST returns 0x11223344, WRITE_FIRST returns 0x1122DDCC; subsequent read returns 0x1122DDCC in both modes.
- 8 back-to-back reads of lines 0..7 holding 0..7 -> 8 consecutive RVALID pulses, RDATA=0..7 in order, for both latencies.
- CLR in IDLE after filling memory with 0xFFFFFFFF; WEN/REN asserted during fill -> no RVALID, no write effect; all lines 0 afterwards.
- RESETn pulsed at fill cycle 100 -> fill restarts, INIT_BUSY high for a full 256 cycles after release; RDATA/RVALID held 0 during reset.
